// File: rtl/twos_to_signmag.sv
// Bit-serial two's-complement to sign/magnitude converter.
// Three-state handshake FSM; one magnitude bit per SHIFT cycle, LSB first.
module twos_to_signmag #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_sign,
  output logic [W-1:0] out_mag,
  output logic         out_zero,
  output logic         out_ovf
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [W-1:0] MIN_MAG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          seen_q;
  logic [W-1:0]  sh_q;
  logic [W-1:0]  sh_d;
  logic          bit_in;
  logic          bit_out;
  logic          valid_q;
  logic          sign_q;
  logic [W-1:0]  mag_q;
  logic          zero_q;
  logic          ovf_q;

  // Serial negation step: once a 1 has passed, later bits are inverted.
  always_comb begin
    bit_in  = sh_q[0];
    bit_out = (sign_q & seen_q) ? ~bit_in : bit_in;
    sh_d    = {bit_out, sh_q[W-1:1]};
  end

  // FSM, shift datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sh_q    <= in_data;
            sign_q  <= in_data[W-1];
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sh_q   <= sh_d;
          seen_q <= seen_q | bit_in;
          if (cnt_q == LAST) begin
            mag_q   <= sh_d;
            zero_q  <= (sh_d == '0);
            ovf_q   <= sign_q & (sh_d == MIN_MAG);
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_sign  = sign_q;
  assign out_mag   = mag_q;
  assign out_zero  = zero_q;
  assign out_ovf   = ovf_q;

endmodule
